ram_fifo: RTL and testbench

RAM_FIFO -- requirements
Module: ram_fifo

---
 rtl/ram_fifo_pkg.sv | 19 +
 rtl/ram_fifo_ram_sdp.sv | 24 ++
 rtl/ram_fifo.sv | 137 +++++++++++++
 tb/tb_ram_fifo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared constants and width helpers for the block-RAM FIFO.
package ram_fifo_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_DEPTH_LOG2 = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Occupancy must be able to represent DEPTH itself, hence one extra bit.
  function automatic int count_bits(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/ram_fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
module ram_sdp
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/ram_fifo.sv
// First-word-fall-through FIFO on a registered-read RAM with an output register
// plus one skid entry, giving one word per cycle when drained continuously.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH             = DEF_WIDTH,
  parameter int DEPTH_LOG2        = DEF_DEPTH_LOG2,
  parameter int ALMOST_FULL_LEVEL = (1 << DEPTH_LOG2) - 4
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic                            clear,
  input  logic [WIDTH-1:0]                in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [count_bits(DEPTH_LOG2)-1:0] count,
  output logic                            almost_full,
  output logic                            protocol_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = clog2(DEPTH);
  localparam int CW    = count_bits(DEPTH_LOG2);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_valid;
  logic             r_rd_pend;
  logic             r_prev_stall;
  logic             r_protocol_error;

  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic [1:0]       w_occ;
  logic [CW-1:0]    w_ram_cnt;
  logic [WIDTH-1:0] w_rdata;

  assign in_ready       = RESET_N & ~clear & (r_count < DEPTH_C);
  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign count          = r_count;
  assign almost_full    = (r_count >= AF_C);
  assign protocol_error = r_protocol_error;

  assign w_push = in_valid & in_ready;
  assign w_pop  = r_out_valid & out_ready;

  // Words already pulled out of the RAM (output reg, skid, read in flight) never exceed two.
  assign w_occ     = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_rd_pend);
  assign w_ram_cnt = r_count - CW'(w_occ);

  // A read only targets words written on an earlier edge, so it never collides with the write.
  assign w_issue = (w_ram_cnt != '0) && ((w_occ < 2'd2) || w_pop) && !clear;

  ram_sdp #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (PW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (in_data),
    .i_re    (w_issue),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_rd_pend    <= 1'b0;
    end else if (clear) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_rd_pend    <= 1'b0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      r_rd_pend <= w_issue;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Skid entry is always older than the word arriving from the RAM.
      if (!r_out_valid || w_pop) begin
        if (r_skid_valid) begin
          r_out_data   <= r_skid_data;
          r_out_valid  <= 1'b1;
          r_skid_valid <= r_rd_pend;
          if (r_rd_pend) r_skid_data <= w_rdata;
        end else if (r_rd_pend) begin
          r_out_data  <= w_rdata;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (r_rd_pend) begin
        r_skid_data  <= w_rdata;
        r_skid_valid <= 1'b1;
      end
    end
  end

  // Sticky until reset; a flush does not hide a producer that withdrew a stalled word.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_prev_stall     <= 1'b0;
      r_protocol_error <= 1'b0;
    end else begin
      r_prev_stall <= in_valid & ~in_ready;
      if (r_prev_stall && !in_valid) r_protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo (16-bit words, 16 deep, almost_full at 12).
module tb_ram_fifo;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  count;
  logic        almost_full;
  logic        protocol_error;

  always #5 CLK = ~CLK;

  ram_fifo #(
    .WIDTH             (16),
    .DEPTH_LOG2        (4),
    .ALMOST_FULL_LEVEL (12)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .clear          (clear),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .almost_full    (almost_full),
    .protocol_error (protocol_error)
  );

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        chk_od;
    logic [15:0] e_od;
    logic [4:0]  e_cnt;
    logic        e_af;
    logic        e_pe;
  } vec_t;

  vec_t        tv[$];
  logic [15:0] q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(input logic rst_n, input logic clr, input logic iv,
                              input logic [15:0] id, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic chk_od, input logic [15:0] e_od,
                              input logic [4:0] e_cnt, input logic e_af, input logic e_pe);
    vec_t v;
    v = '{rst_n, clr, iv, id, ordy, e_ir, e_ov, chk_od, e_od, e_cnt, e_af, e_pe};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int wn;
    int seen;
    logic pushed;

    RESET_N   = 1'b0;
    clear     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Expected values are the outputs just after the edge, inputs still applied.
    tv.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 5'd0, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 5'd0, 0, 0));
    tv.push_back(mk(1, 0, 1, 16'hA50F, 0, 1, 0, 0, 16'h0000, 5'd1, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 5'd1, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 1, 16'hA50F, 5'd1, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 5'd0, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 5'd0, 0, 0));
    for (int i = 0; i < 7; i++)
      tv.push_back(mk(1, 0, 1, 16'(16'h0101 + i), 0, 1, (i >= 2), (i >= 2), 16'h0101,
                      5'(i + 1), 0, 0));
    tv.push_back(mk(1, 1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 5'd0, 0, 0));
    tv.push_back(mk(1, 0, 1, 16'h7777, 0, 1, 0, 0, 16'h0000, 5'd1, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 5'd1, 0, 0));
    tv.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 5'd0, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 5'd0, 0, 0));
    tv.push_back(mk(1, 0, 1, 16'h1234, 0, 1, 0, 0, 16'h0000, 5'd1, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 5'd1, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 0, 1, 1, 1, 16'h1234, 5'd1, 0, 0));
    tv.push_back(mk(1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 5'd0, 0, 0));

    foreach (tv[i]) begin
      RESET_N   = tv[i].rst_n;
      clear     = tv[i].clr;
      in_valid  = tv[i].iv;
      in_data   = tv[i].id;
      out_ready = tv[i].ordy;
      step();
      chk($sformatf("v%0d.in_ready", i), in_ready, tv[i].e_ir);
      chk($sformatf("v%0d.out_valid", i), out_valid, tv[i].e_ov);
      if (tv[i].chk_od) chk($sformatf("v%0d.out_data", i), out_data, tv[i].e_od);
      chk($sformatf("v%0d.count", i), count, tv[i].e_cnt);
      chk($sformatf("v%0d.almost_full", i), almost_full, tv[i].e_af);
      chk($sformatf("v%0d.protocol_error", i), protocol_error, tv[i].e_pe);
    end
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Fill to capacity with the consumer stalled.
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      step();
      chk($sformatf("fill%0d.count", i), count, 32'(i));
      chk($sformatf("fill%0d.almost_full", i), almost_full, (i >= 12));
      chk($sformatf("fill%0d.in_ready", i), in_ready, (i < 16));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Drain: one word per cycle, strictly in order.
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("drain%0d.out_valid", k), out_valid, 1);
      chk($sformatf("drain%0d.out_data", k), out_data, 32'(k));
      step();
      chk($sformatf("drain%0d.count", k), count, 32'(16 - k));
    end
    chk("drain.out_valid_end", out_valid, 0);
    chk("drain.protocol_error", protocol_error, 0);

    // Streaming 40 words through a 16-deep FIFO with a scoreboard.
    wn   = 0;
    seen = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 150 && seen < 40; c++) begin
      if (out_valid) begin
        if (q.size() == 0) chk("stream.spurious_valid", out_valid, 0);
        else begin
          chk($sformatf("stream%0d.data", seen), out_data, q.pop_front());
          seen++;
        end
      end
      in_valid = (wn < 40);
      in_data  = 16'(16'h4000 + wn);
      pushed   = in_valid && in_ready;
      if (pushed) begin
        q.push_back(in_data);
        wn++;
      end
      step();
      if (pushed && wn >= 3) chk($sformatf("stream%0d.count", wn), count, 3);
    end
    in_valid = 1'b0;
    chk("stream.words_seen", seen, 40);
    chk("stream.count_end", count, 0);
    chk("stream.out_valid_end", out_valid, 0);

    // Full with simultaneous write and read, then a withdrawn stalled word.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h2000 + i);
      step();
    end
    chk("full.count", count, 16);
    chk("full.in_ready", in_ready, 0);
    in_data   = 16'h3000;
    out_ready = 1'b1;
    step();
    chk("fullrw.count", count, 15);
    chk("fullrw.in_ready", in_ready, 1);
    chk("fullrw.protocol_error", protocol_error, 0);
    out_ready = 1'b0;
    step();
    chk("refill.count", count, 16);
    chk("refill.out_data", out_data, 16'h2001);
    step();
    chk("stall.protocol_error", protocol_error, 0);
    in_valid = 1'b0;
    step();
    chk("drop.protocol_error", protocol_error, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear.count", count, 0);
    chk("clear.out_valid", out_valid, 0);
    chk("clear.protocol_error", protocol_error, 1);
    RESET_N = 1'b0;
    step();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.count", count, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.almost_full", almost_full, 0);
    chk("rst.protocol_error", protocol_error, 0);
    RESET_N = 1'b1;
    step();
    chk("rel.in_ready", in_ready, 1);
    chk("rel.count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
